imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, memory depth in 32-bit words.
REQ-002 SHALL have parameter MAX_WAIT, default 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-003 SHALL have port clk_i, input, 1, single clock.
REQ-004 SHALL have port rst_i, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have ports fetch_req_i in 1, fetch_addr_i in 32 (byte address), fetch_gnt_o out 1, fetch_rvalid_o out 1, fetch_rdata_o out 32, fetch_err_o out 1.
REQ-006 SHALL have ports load_req_i in 1, load_we_i in 1, load_addr_i in 32 (byte address), load_wdata_i in 32, load_gnt_o out 1, load_rvalid_o out 1, load_rdata_o out 32, load_err_o out 1.
REQ-007 SHALL have memory-side ports mem_en_o out 1, mem_we_o out 1, mem_addr_o out $clog2(MEM_SIZE), mem_wdata_o out 32, mem_rdata_i in 32 (synchronous read, 1-cycle latency).

Function
REQ-008 SHALL grant at most one requester per cycle; the grant is combinational, in the same cycle as the request.
REQ-009 SHALL, when only one port requests, grant that port.
REQ-010 SHALL, when both ports request, grant load unless the starvation counter equals MAX_WAIT, in which case it grants fetch.
REQ-011 SHALL increment the starvation counter on each cycle with fetch_req_i=1 and fetch_gnt_o=0, and clear it on a fetch grant or when fetch_req_i=0; the counter saturates at MAX_WAIT.
REQ-012 SHALL drive the mem_* outputs from the granted port: mem_addr_o = addr[2 +: $clog2(MEM_SIZE)]; mem_we_o = load_we_i only when load is granted, else 0; mem_en_o = 1 only when a grant occurs.
REQ-013 SHALL register the owner of each accepted read (OWN_NONE/OWN_FETCH/OWN_LOAD) and, one cycle later, assert exactly one of fetch_rvalid_o/load_rvalid_o for one cycle with rdata = mem_rdata_i.
REQ-014 SHALL NOT produce an rvalid for a granted load write; a write completes at grant.
REQ-015 SHALL hold fetch_rdata_o/load_rdata_o at their last returned value when the corresponding rvalid is low.
REQ-016 SHALL sustain back-to-back grants, one per cycle, with no bubble between them.
REQ-017 SHALL treat the request inputs as unqualified: the requester holds req/addr/data until it sees gnt in that cycle.

Reset
REQ-018 SHALL, while rst_i=1: all gnt, rvalid, err, mem_en_o and mem_we_o = 0; rdata outputs = 0; owner = OWN_NONE; starvation counter = 0.
REQ-019 SHALL discard a read in flight when reset asserts mid-operation; no rvalid follows the reset release.

Configuration
REQ-020 SHALL, with IMEM_ARB_ERR_EN defined, flag misaligned (addr[1:0]!=0) or out-of-range (addr >= 4*MEM_SIZE) requests: the request is still granted, mem_en_o=0, and err_o plus rvalid_o rise one cycle later with rdata=0 (for a write, err_o alone rises one cycle later).
REQ-021 SHALL, without IMEM_ARB_ERR_EN, tie both err outputs to 0, perform no address check and let the index truncate.

Structure
REQ-022 SHALL place the owner enum typedef and the default MAX_WAIT constant in the shared package imem_pkg.
REQ-023 SHALL be a single module with no sub-modules; the memory array stays external.

Verification
REQ-024 SHALL cover: fetch only, addr 0x8 with mem[2]=0xDEADBEEF -> fetch_gnt_o same cycle, fetch_rvalid_o next cycle, rdata 0xDEADBEEF.
REQ-025 SHALL cover: load write addr 0x10 data 0x12345678, then fetch 0x10 -> mem_we_o=1 for one cycle, no load_rvalid_o, then fetch returns 0x12345678.
REQ-026 SHALL cover: both ports requesting for 10 cycles with MAX_WAIT=4 -> load granted 4 cycles, fetch on the 5th, pattern repeats.
REQ-027 SHALL cover: rst_i pulse the cycle after a fetch grant -> all outputs 0, no fetch_rvalid_o after release.
REQ-028 SHALL cover, with IMEM_ARB_ERR_EN: fetch 0x2 and fetch 0x1000 with MEM_SIZE=1024 -> mem_en_o=0, fetch_err_o=1 and fetch_rvalid_o=1 with rdata 0; without the macro, fetch_err_o stays 0.
REQ-029 SHALL cover: alternating single-cycle fetch/load reads for 8 cycles -> 8 rvalids, each on the correct port in order, no dropped response.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package imem_pkg;

    // Which port owns the read currently returning from the memory.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    // Denied fetch cycles tolerated before fetch is forced to win.
    localparam int MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/imem_arbiter.sv
// Two-port arbiter (instruction fetch, load/store) in front of a single
// external synchronous-read memory with one-cycle read latency.
// Load has priority; a starvation counter forces a fetch grant after
// MAX_WAIT consecutive denied fetch cycles.
// Optional feature: define IMEM_ARB_ERR_EN to flag misaligned or
// out-of-range requests (granted, memory not enabled, error response).
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        fetch_req_i,
    input  logic [31:0]                 fetch_addr_i,
    output logic                        fetch_gnt_o,
    output logic                        fetch_rvalid_o,
    output logic [31:0]                 fetch_rdata_o,
    output logic                        fetch_err_o,

    input  logic                        load_req_i,
    input  logic                        load_we_i,
    input  logic [31:0]                 load_addr_i,
    input  logic [31:0]                 load_wdata_i,
    output logic                        load_gnt_o,
    output logic                        load_rvalid_o,
    output logic [31:0]                 load_rdata_o,
    output logic                        load_err_o,

    output logic                        mem_en_o,
    output logic                        mem_we_o,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    input  logic [31:0]                 mem_rdata_i
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] starv_q, starv_d;
    owner_t        owner_q, owner_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic [31:0]   fetch_hold_q, load_hold_q;
    logic [31:0]   rsp_data;

    logic          fetch_gnt, load_gnt;
    logic          fetch_bad, load_bad;

`ifdef IMEM_ARB_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_SIZE);

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction

    assign fetch_bad = addr_bad(fetch_addr_i);
    assign load_bad  = addr_bad(load_addr_i);
`else
    // Without checking, the word index simply truncates the byte address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr_i[31:AW+2], fetch_addr_i[1:0],
                                load_addr_i[31:AW+2],  load_addr_i[1:0]};
    assign fetch_bad = 1'b0;
    assign load_bad  = 1'b0;
`endif

    // Same-cycle grant: load wins unless fetch has starved for MAX_WAIT cycles.
    always_comb begin
        load_gnt  = 1'b0;
        fetch_gnt = 1'b0;
        if (!rst_i) begin
            if (load_req_i && !(fetch_req_i && (starv_q == WAIT_MAX))) begin
                load_gnt = 1'b1;
            end else if (fetch_req_i) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    assign fetch_gnt_o = fetch_gnt;
    assign load_gnt_o  = load_gnt;

    // Steer the granted port onto the memory; flagged requests never reach it.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (load_gnt) begin
            mem_en_o    = ~load_bad;
            mem_we_o    = load_we_i & ~load_bad;
            mem_addr_o  = load_addr_i[2 +: AW];
            mem_wdata_o = load_wdata_i;
        end else if (fetch_gnt) begin
            mem_en_o    = ~fetch_bad;
            mem_addr_o  = fetch_addr_i[2 +: AW];
        end
    end

    // Starvation count: grows while fetch is refused, clears otherwise.
    always_comb begin
        starv_d = '0;
        if (fetch_req_i && !fetch_gnt) begin
            starv_d = (starv_q == WAIT_MAX) ? starv_q : starv_q + 1'b1;
        end
    end

    // Decide who owns next cycle's response; a clean write needs none.
    always_comb begin
        owner_d   = OWN_NONE;
        rsp_err_d = 1'b0;
        rsp_wr_d  = 1'b0;
        if (fetch_gnt) begin
            owner_d   = OWN_FETCH;
            rsp_err_d = fetch_bad;
        end else if (load_gnt) begin
            if (!load_we_i) begin
                owner_d   = OWN_LOAD;
                rsp_err_d = load_bad;
            end else if (load_bad) begin
                owner_d   = OWN_LOAD;
                rsp_err_d = 1'b1;
                rsp_wr_d  = 1'b1;
            end
        end
    end

    // Owner and starvation registers; reset drops any read in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q   <= OWN_NONE;
            rsp_err_q <= 1'b0;
            rsp_wr_q  <= 1'b0;
            starv_q   <= '0;
        end else begin
            owner_q   <= owner_d;
            rsp_err_q <= rsp_err_d;
            rsp_wr_q  <= rsp_wr_d;
            starv_q   <= starv_d;
        end
    end

    assign fetch_rvalid_o = (owner_q == OWN_FETCH);
    assign load_rvalid_o  = (owner_q == OWN_LOAD) && !rsp_wr_q;
    assign rsp_data       = rsp_err_q ? 32'h0 : mem_rdata_i;

`ifdef IMEM_ARB_ERR_EN
    assign fetch_err_o = (owner_q == OWN_FETCH) && rsp_err_q;
    assign load_err_o  = (owner_q == OWN_LOAD) && rsp_err_q;
`else
    assign fetch_err_o = 1'b0;
    assign load_err_o  = 1'b0;
`endif

    // Keep the last returned word on each port while its rvalid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_hold_q <= '0;
            load_hold_q  <= '0;
        end else begin
            if (fetch_rvalid_o) fetch_hold_q <= rsp_data;
            if (load_rvalid_o)  load_hold_q  <= rsp_data;
        end
    end

    assign fetch_rdata_o = fetch_rvalid_o ? rsp_data : fetch_hold_q;
    assign load_rdata_o  = load_rvalid_o  ? rsp_data : load_hold_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a behavioural synchronous memory.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, load_req, load_we;
    logic [31:0] fetch_addr, load_addr, load_wdata;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic        load_gnt, load_rvalid, load_err;
    logic [31:0] fetch_rdata, load_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_SIZE(1024), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid),
        .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
        .load_req_i(load_req), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .load_gnt_o(load_gnt),
        .load_rvalid_o(load_rvalid), .load_rdata_o(load_rdata),
        .load_err_o(load_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [3:0]  flags;   // {fetch_rvalid, load_rvalid, fetch_err, load_err}
        logic [31:0] data;
        string       name;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input string name, input logic [3:0] fl, input logic [31:0] d);
        exp_q.push_back('{fl, d, name});
    endtask

    // Monitor: every response the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (!rst && (fetch_rvalid || load_rvalid || fetch_err || load_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got flags %b expected none",
                         {fetch_rvalid, load_rvalid, fetch_err, load_err});
            end else begin
                cur = exp_q.pop_front();
                chk({cur.name, "_flags"}, 32'({fetch_rvalid, load_rvalid, fetch_err, load_err}),
                    32'(cur.flags));
                chk({cur.name, "_data"}, fetch_rvalid ? fetch_rdata : load_rdata, cur.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0; load_req = 1'b0; load_we = 1'b0;
        fetch_addr = '0; load_addr = '0; load_wdata = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_fgnt"},   32'(fetch_gnt), 0);
        chk({tag, "_lgnt"},   32'(load_gnt), 0);
        chk({tag, "_frv"},    32'(fetch_rvalid), 0);
        chk({tag, "_lrv"},    32'(load_rvalid), 0);
        chk({tag, "_ferr"},   32'(fetch_err), 0);
        chk({tag, "_lerr"},   32'(load_err), 0);
        chk({tag, "_men"},    32'(mem_en), 0);
        chk({tag, "_mwe"},    32'(mem_we), 0);
        chk({tag, "_frdata"}, fetch_rdata, 0);
        chk({tag, "_lrdata"}, load_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h0BAD_F00D;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'hDEAD_BEEF;
        for (int i = 8; i < 16; i++) mem[i] = 32'hA000_0000 + i;

        // Reset: outputs quiet even with a fetch request pending.
        rst = 1'b1;
        idle();
        fetch_req = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_quiet("reset");
        tick();
        idle();
        rst = 1'b0;
        tick();

        // Fetch 0x8 -> mem[2].
        fetch_req = 1'b1; fetch_addr = 32'h8;
        @(negedge clk);
        chk("f8_gnt", 32'(fetch_gnt), 1);
        chk("f8_lgnt", 32'(load_gnt), 0);
        chk("f8_men", 32'(mem_en), 1);
        chk("f8_maddr", 32'(mem_addr), 2);
        expect_rsp("f8", 4'b1000, 32'hDEAD_BEEF);
        tick(); idle();
        tick();
        @(negedge clk);
        chk("f8_hold_rv", 32'(fetch_rvalid), 0);
        chk("f8_hold", fetch_rdata, 32'hDEAD_BEEF);
        tick();

        // Write 0x10, then fetch it back; the write has no response.
        load_req = 1'b1; load_we = 1'b1; load_addr = 32'h10; load_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wr_gnt", 32'(load_gnt), 1);
        chk("wr_mwe", 32'(mem_we), 1);
        chk("wr_men", 32'(mem_en), 1);
        chk("wr_maddr", 32'(mem_addr), 4);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        tick(); idle();
        fetch_req = 1'b1; fetch_addr = 32'h10;
        @(negedge clk);
        chk("wr_lrv", 32'(load_rvalid), 0);
        chk("wr_mwe_off", 32'(mem_we), 0);
        chk("f10_gnt", 32'(fetch_gnt), 1);
        expect_rsp("f10", 4'b1000, 32'h1234_5678);
        tick(); idle();
        tick();

        // Both requesting 10 cycles: L L L L F L L L L F.
        pat = 10'b0111101111;
        fetch_req = 1'b1; fetch_addr = 32'h4;
        load_req = 1'b1; load_we = 1'b0; load_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve%0d_lgnt", i), 32'(load_gnt), 32'(pat[i]));
            chk($sformatf("starve%0d_fgnt", i), 32'(fetch_gnt), 32'(!pat[i]));
            if (pat[i]) expect_rsp($sformatf("starve%0d", i), 4'b0100, 32'h0BAD_F00D);
            else        expect_rsp($sformatf("starve%0d", i), 4'b1000, 32'h1111_1111);
            tick();
        end
        idle();
        tick();

        // Misaligned and out-of-range fetches, back to back.
        for (int i = 0; i < 2; i++) begin
            fetch_req = 1'b1;
            fetch_addr = (i == 0) ? 32'h2 : 32'h1000;
            @(negedge clk);
            chk($sformatf("bad%0d_gnt", i), 32'(fetch_gnt), 1);
`ifdef IMEM_ARB_ERR_EN
            chk($sformatf("bad%0d_men", i), 32'(mem_en), 0);
            expect_rsp($sformatf("bad%0d", i), 4'b1010, 32'h0);
`else
            chk($sformatf("bad%0d_men", i), 32'(mem_en), 1);
            expect_rsp($sformatf("bad%0d", i), 4'b1000, 32'h0BAD_F00D);
`endif
            tick();
        end
        idle();
        tick();

        // Alternating single-cycle fetch/load reads of mem[8..15].
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin
                fetch_req = 1'b1; fetch_addr = 32'(4 * (8 + i));
            end else begin
                load_req = 1'b1; load_addr = 32'(4 * (8 + i));
            end
            @(negedge clk);
            chk($sformatf("alt%0d_gnt", i), 32'(fetch_gnt | load_gnt), 1);
            chk($sformatf("alt%0d_port", i), 32'(load_gnt), 32'(i % 2));
            expect_rsp($sformatf("alt%0d", i), (i % 2 == 0) ? 4'b1000 : 4'b0100,
                       32'hA000_0000 + 32'(8 + i));
            tick();
        end
        idle();
        tick(); tick();

        // Reset the cycle after a fetch grant: the read must be dropped.
        fetch_req = 1'b1; fetch_addr = 32'h8;
        @(negedge clk);
        chk("rstf_gnt", 32'(fetch_gnt), 1);
        tick(); idle();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("midrst");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_frv", 32'(fetch_rvalid), 0);
        tick(); tick();

        chk("drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
